// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a one-byte holding register.
// DATA (addr 0) pushes a byte; STATUS (addr 1) reports busy/hold_full/overflow.
module uart_tx_mmio #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic        addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(7);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [7:0]       shift, shift_nx;
  logic [7:0]       hold, hold_nx;
  logic             hold_full, hold_full_nx;
  logic             overflow, overflow_nx;
  logic             tx_nx;

  logic push, stat_wr, load, accept, bit_done, busy;
  logic unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  assign push     = sel && we && (addr == 1'b0);
  assign stat_wr  = sel && we && (addr == 1'b1);
  assign bit_done = (cnt == CNT_LAST);
  assign busy     = (state != S_IDLE);

  // Register bank; synchronous reset aborts any frame and drops the queued byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      overflow  <= 1'b0;
      tx        <= 1'b1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      idx       <= idx_nx;
      shift     <= shift_nx;
      hold      <= hold_nx;
      hold_full <= hold_full_nx;
      overflow  <= overflow_nx;
      tx        <= tx_nx;
    end
  end

  // Next-state logic; tx is derived from the next state so it is registered.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    idx_nx       = idx;
    shift_nx     = shift;
    hold_nx      = hold;
    hold_full_nx = hold_full;
    overflow_nx  = overflow;
    load         = 1'b0;
    accept       = 1'b0;
    tx_nx        = 1'b1;

    case (state)
      S_IDLE: begin
        if (hold_full) begin
          load     = 1'b1;
          state_nx = S_START;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
      end
      S_START: begin
        if (bit_done) begin
          state_nx = S_DATA;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_done) begin
          cnt_nx   = '0;
          shift_nx = shift >> 1;
          idx_nx   = idx + IDX_W'(1);
          if (idx == IDX_LAST) begin
            state_nx = S_STOP;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_done) begin
          cnt_nx = '0;
          idx_nx = '0;
          if (hold_full) begin
            load     = 1'b1;
            state_nx = S_START;
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
        idx_nx   = '0;
      end
    endcase

    if (load) begin
      shift_nx     = hold;
      hold_full_nx = 1'b0;
    end

    // A push lands if the holding register is free or being drained this cycle.
    accept = push && (!hold_full || load);
    if (accept) begin
      hold_nx      = wdata[7:0];
      hold_full_nx = 1'b1;
    end

    if (push && !accept) begin
      overflow_nx = 1'b1;
    end else if (stat_wr) begin
      overflow_nx = 1'b0;
    end

    case (state_nx)
      S_START: tx_nx = 1'b0;
      S_DATA:  tx_nx = shift_nx[0];
      default: tx_nx = 1'b1;
    endcase
  end

  // Read mux is combinational on addr only.
  always_comb begin
    rdata = '0;
    if (addr) begin
      rdata[2:0] = {overflow, hold_full, busy};
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with CLKS_PER_BIT=4: table of single frames
// plus hand-written back-to-back, overflow, same-cycle load/push and reset cases.
module tb_uart_tx_mmio;

  localparam int unsigned CPB = 4;

  logic        clk;
  logic        reset;
  logic        sel;
  logic        we;
  logic        addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t vecs[4];

  uart_tx_mmio #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .tx    (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_status(input string name, input logic [31:0] exp);
    addr = 1'b1;
    #1;
    check(name, rdata, exp);
  endtask

  // Drives at the current negedge; captured at the next posedge; returns at the following negedge.
  task automatic write(input logic a, input logic [7:0] d);
    sel   = 1'b1;
    we    = 1'b1;
    addr  = a;
    wdata = {24'h0, d};
    @(negedge clk);
    sel   = 1'b0;
    we    = 1'b0;
    wdata = '0;
    addr  = 1'b1;
  endtask

  // Checks tx for frame-relative cycles from+1..to; cycle 1 is the first start-bit cycle.
  task automatic expect_frame(input logic [9:0] f, input int from, input int to, input string name);
    for (int c = from + 1; c <= to; c++) begin
      @(negedge clk);
      check($sformatf("%s tx c%0d", name, c), {31'h0, tx}, {31'h0, f[(c - 1) / CPB]});
    end
  endtask

  initial begin
    int lows;
    n_cmp = 0;
    n_bad = 0;
    vecs[0] = '{data: 8'hA5, frame: 10'h34A};
    vecs[1] = '{data: 8'h00, frame: 10'h200};
    vecs[2] = '{data: 8'hFF, frame: 10'h3FE};
    vecs[3] = '{data: 8'h3C, frame: 10'h278};

    sel   = 1'b0;
    we    = 1'b0;
    addr  = 1'b1;
    wdata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset then idle
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check($sformatf("idle tx %0d", i), {31'h0, tx}, 32'h1);
      check_status($sformatf("idle status %0d", i), 32'h0);
    end

    // Table of single frames into an idle block
    for (int i = 0; i < 4; i++) begin
      write(1'b0, vecs[i].data);
      check_status($sformatf("v%0d queued status", i), 32'h2);
      check($sformatf("v%0d queued tx", i), {31'h0, tx}, 32'h1);
      expect_frame(vecs[i].frame, 0, 40, $sformatf("v%0d", i));
      @(negedge clk);
      check_status($sformatf("v%0d done status", i), 32'h0);
      check($sformatf("v%0d done tx", i), {31'h0, tx}, 32'h1);
    end

    // Back-to-back: second byte written while first is in START
    write(1'b0, 8'h55);
    check_status("b2b queued status", 32'h2);
    @(negedge clk);
    check("b2b start tx", {31'h0, tx}, 32'h0);
    write(1'b0, 8'h0F);
    check_status("b2b second write status", 32'h3);
    expect_frame(10'h2AA, 2, 40, "b2b first");
    expect_frame(10'h21E, 0, 40, "b2b second");
    @(negedge clk);
    check_status("b2b done status", 32'h0);

    // Overflow on three consecutive pushes, then clear while busy
    write(1'b0, 8'h11);
    write(1'b0, 8'h22);
    write(1'b0, 8'h33);
    check_status("ovf set status", 32'h7);
    write(1'b1, 8'h00);
    check_status("ovf clear status", 32'h3);
    expect_frame(10'h222, 3, 40, "ovf 0x11");
    expect_frame(10'h244, 0, 40, "ovf 0x22");
    @(negedge clk);
    check_status("ovf done status", 32'h0);
    check("ovf done tx", {31'h0, tx}, 32'h1);

    // Push on the last STOP cycle while the FSM drains the holding register
    write(1'b0, 8'h00);
    write(1'b0, 8'hFF);
    expect_frame(10'h200, 1, 40, "slp 0x00");
    check_status("slp last stop status", 32'h3);
    write(1'b0, 8'h44);
    check_status("slp after push status", 32'h3);
    expect_frame(10'h3FE, 1, 40, "slp 0xFF");
    expect_frame(10'h288, 0, 40, "slp 0x44");
    @(negedge clk);
    check_status("slp done status", 32'h0);

    // Reset during data bit 3 with a byte queued
    write(1'b0, 8'hA5);
    write(1'b0, 8'h5A);
    expect_frame(10'h34A, 1, 18, "rst frame");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst tx", {31'h0, tx}, 32'h1);
    check_status("rst status", 32'h0);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("rst no further frames", 32'(lows), 32'h0);
    check_status("rst final status", 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter (8N1) that serialises bytes stored by the RISC-V core and drives the board pin `ck_io0`. It sits downstream of the core's data-memory bus decode: a store to its address window pushes a byte; loads return status. A one-byte holding register in front of the shift register lets software queue the next byte while the current one is on the line.

## Interface
- `CLKS_PER_BIT`, 217, clock cycles per serial bit (25 MHz core clock / 115200 baud); legal range 2..65535.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `sel`  in  1  bus select for this peripheral's window (from the address decode).
- `we`  in  1  write enable; qualified by `sel`.
- `addr`  in  1  word offset: 0 = DATA, 1 = STATUS.
- `wdata`  in  32  write data; DATA uses `[7:0]`.
- `rdata`  out  32  combinational read data for the current `addr`.
- `tx`  out  1  serial line to `ck_io0`; registered; idle high.

## Operation
- Registers:
  - DATA, write-only: a write pushes `wdata[7:0]` into the holding register. Reads return 0.
  - STATUS, read: bit0 `busy` (FSM not IDLE), bit1 `hold_full`, bit2 `overflow` (sticky); bits 31:3 read 0.
  - STATUS, write: any value clears `overflow`.
- Push acceptance: a DATA write is accepted if `hold_full`=0, or if the FSM empties the holding register in the same cycle.
  - Otherwise the write is dropped, the holding register is left unchanged, and `overflow` is set.
- FSM states IDLE, START, DATA, STOP. A bit counter (0..CLKS_PER_BIT-1) and a bit index (0..7) control the states.
  - IDLE: `tx`=1. If `hold_full`, load the shift register from the holding register, clear `hold_full`, reset the counters, and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `tx`=shift[0]; bits are sent LSB first. After CLKS_PER_BIT cycles, shift right and increment the index. After the 8th bit, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. Then, if `hold_full`, load the next byte and go directly to START (back-to-back, no idle gap). Otherwise go to IDLE.
- Simultaneous events:
  - If the FSM loads from the holding register and a DATA write occurs in the same cycle, the new byte is accepted and `hold_full` stays 1.
  - If a STATUS write and an overflowing DATA write occur in the same cycle, the set wins and `overflow`=1.
- `sel`=0 blocks all writes. `rdata` is valid whenever `addr` is stable; `sel` does not gate it.

## Timing
- Reset values: `tx`=1, FSM=IDLE, `hold_full`=0, `overflow`=0, counters=0, shift register=0. `rdata` for STATUS reads 0.
- Reset applied mid-frame aborts the frame. `tx` is 1 on the cycle after the reset edge, and any queued byte is discarded.
- Latency from a DATA write into an idle block:
  - Write captured at edge N: `hold_full`=1 after N.
  - FSM enters START at edge N+1: `tx`=0 and `busy`=1 after N+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles, measured from the `tx` falling edge to the end of the stop bit.
- A back-to-back frame's start bit begins on the cycle immediately after the last stop-bit cycle.
- `busy` falls on the edge that enters IDLE, i.e. exactly 10·CLKS_PER_BIT cycles after it rose, when nothing is queued.

## Test plan
- Reset then idle, with CLKS_PER_BIT=4: hold `reset` for 2 cycles, then release. Required: `tx`=1, STATUS=0 for 50 cycles.
- Single byte 0xA5, written at cycle N:
  - `tx`=0 over cycles N+1..N+4.
  - Data bits 1,0,1,0,0,1,0,1 (LSB first), 4 cycles each.
  - Stop bit high for 4 cycles.
  - `busy`=0 at N+41.
- Back-to-back: write 0x55, then write 0x0F while the first byte is in START.
  - STATUS=0x3 after the second write.
  - The second start bit begins immediately after the first stop bit; there is no high gap beyond 4 cycles.
  - The total of both frames is 80 cycles.
- Overflow: write 0x11, 0x22, 0x33 on consecutive cycles.
  - 0x11 and 0x22 are transmitted; 0x33 is dropped.
  - STATUS bit2=1.
  - A STATUS write clears bit2 and leaves the other bits unchanged.
- Same-cycle load and push: write 0x44 on exactly the last STOP cycle of a frame while `hold_full`=1. Required: no overflow; both queued bytes are transmitted in order.
- Reset mid-frame: assert `reset` during DATA bit 3 with one byte queued.
  - `tx`=1 the cycle after reset, STATUS=0.
  - No further frames are sent.
